// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode controller for a two-instruction subset (addi, bne): fetches from
// instruction memory, decodes register fields and controls, and steps the PC.
module fetch_decode_ctrl #(
    parameter int                  A_WIDTH  = 32,
    parameter int                  D_WIDTH  = 32,
    parameter logic [A_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [A_WIDTH-1:0] imem_addr,
    input  logic [D_WIDTH-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               EQ,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic               ALUsrc,
    output logic               ALUctrl,
    output logic [D_WIDTH-1:0] ImmOp,
    output logic               RegWrite,
    output logic [A_WIDTH-1:0] pc,
    output logic               halt,
    output logic [1:0]         o_dbg_state
);

    // imem handshake: in FETCH imem_req stays high and imem_addr stays at pc
    // until the cycle imem_valid is seen high; that cycle's imem_rdata is taken.
    // imem_valid is ignored in every other state.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [A_WIDTH-1:0] r_pc;
    logic [A_WIDTH-1:0] w_next_pc;
    logic [D_WIDTH-1:0] r_ir;
    logic [D_WIDTH-1:0] w_next_ir;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic               w_is_addi;
    logic               w_is_bne;
    logic [D_WIDTH-1:0] w_imm_i;
    logic [D_WIDTH-1:0] w_imm_b;
    logic [A_WIDTH-1:0] w_target;
    logic [A_WIDTH-1:0] w_seq_pc;

    assign w_opcode  = r_ir[6:0];
    assign w_funct3  = r_ir[14:12];
    assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_is_bne  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b001);

    assign w_imm_i = D_WIDTH'($signed(r_ir[31:20]));
    assign w_imm_b = D_WIDTH'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));

    assign rs1     = r_ir[19:15];
    assign rs2     = r_ir[24:20];
    assign rd      = r_ir[11:7];
    assign ALUsrc  = w_is_addi;
    assign ALUctrl = w_is_bne;
    assign ImmOp   = w_is_bne ? w_imm_b : w_imm_i;

    // Both additions wrap naturally at A_WIDTH bits.
    assign w_target = r_pc + A_WIDTH'($signed(ImmOp));
    assign w_seq_pc = r_pc + A_WIDTH'(4);

    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign halt        = (r_state == HALT);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_ir    <= w_next_ir;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_ir    = r_ir;
        imem_req     = 1'b0;
        RegWrite     = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    w_next_ir    = imem_rdata;
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                if (w_is_addi) begin
                    RegWrite     = 1'b1;
                    w_next_pc    = w_seq_pc;
                    w_next_state = FETCH;
                end else if (w_is_bne) begin
                    if (!EQ) begin
                        // A misaligned taken target stops the core with pc intact.
                        if (w_target[1:0] != 2'b00) begin
                            w_next_state = HALT;
                        end else begin
                            w_next_pc    = w_target;
                            w_next_state = FETCH;
                        end
                    end else begin
                        w_next_pc    = w_seq_pc;
                        w_next_state = FETCH;
                    end
                end else begin
                    w_next_state = HALT;
                end
            end
            HALT: begin
                w_next_state = HALT;
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: decode vector table, directed reset/branch/halt
// sequences, and random addi/bne/illegal streams against an instruction-level model.
module tb_fetch_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        EQ;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] ImmOp;
    logic        RegWrite;
    logic [31:0] pc;
    logic        halt;
    logic [1:0]  o_dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];

    fetch_decode_ctrl #(
        .A_WIDTH  (32),
        .D_WIDTH  (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .EQ          (EQ),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .ALUsrc      (ALUsrc),
        .ALUctrl     (ALUctrl),
        .ImmOp       (ImmOp),
        .RegWrite    (RegWrite),
        .pc          (pc),
        .halt        (halt),
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_valid = 1'b0;
        EQ         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // From FETCH: wait some cycles with imem_valid low, then deliver one word.
    task automatic fetch_to_exec(input logic [31:0] instr, input int waits, input string tag);
        for (int w = 0; w < waits; w++) begin
            check({tag, "_wait_req"}, 32'(imem_req), 32'd1);
            check({tag, "_wait_rw"}, 32'(RegWrite), 32'd0);
            tick();
        end
        imem_valid = 1'b1;
        imem_rdata = instr;
        tick();
        imem_valid = 1'b0;
        imem_rdata = $urandom;
    endtask

    function automatic logic [31:0] enc_addi(logic [11:0] imm, logic [4:0] s1, logic [4:0] d);
        return {imm, s1, 3'b000, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_bne(logic [12:0] imm, logic [4:0] s1, logic [4:0] s2);
        return {imm[12], imm[10:5], s2, s1, 3'b001, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // ---------------- decode vector table ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic        eq;
        logic        legal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        alusrc;
        logic        aluctrl;
        logic        regwrite;
        logic [31:0] imm;
        logic [31:0] next_pc;
        logic        halt;
    } vec_t;

    vec_t vecs[10];

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] m_pc;
        logic [31:0] exp_pc;
        logic [31:0] instr;
        logic [31:0] tgt;
        logic [11:0] imm12;
        logic [12:0] imm13;
        logic [4:0]  f_rd;
        logic [4:0]  f_rs1;
        logic [4:0]  f_rs2;
        logic        eq;
        logic        exp_halt;
        int          kind;
        int          simm;
        int          off;

        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = '0;
        EQ         = 1'b0;

        //            instr         eq    legal rd     rs1    rs2    src   ctrl  rw    imm            next_pc        halt
        vecs[0] = '{32'h0FF00513, 1'b0, 1'b1, 5'd10, 5'd0, 5'd31, 1'b1, 1'b0, 1'b1, 32'h000000FF, 32'h00000004, 1'b0};
        vecs[1] = '{32'hFFF10093, 1'b0, 1'b1, 5'd1,  5'd2, 5'd31, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000004, 1'b0};
        vecs[2] = '{32'h00209463, 1'b0, 1'b1, 5'd8,  5'd1, 5'd2,  1'b0, 1'b1, 1'b0, 32'h00000008, 32'h00000008, 1'b0};
        vecs[3] = '{32'h00209463, 1'b1, 1'b1, 5'd8,  5'd1, 5'd2,  1'b0, 1'b1, 1'b0, 32'h00000008, 32'h00000004, 1'b0};
        vecs[4] = '{32'h00209363, 1'b0, 1'b1, 5'd6,  5'd1, 5'd2,  1'b0, 1'b1, 1'b0, 32'h00000006, 32'h00000000, 1'b1};
        vecs[5] = '{32'h00209363, 1'b1, 1'b1, 5'd6,  5'd1, 5'd2,  1'b0, 1'b1, 1'b0, 32'h00000006, 32'h00000004, 1'b0};
        vecs[6] = '{32'h00000033, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
        vecs[7] = '{32'h00001093, 1'b0, 1'b0, 5'd1,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
        vecs[8] = '{32'h00000063, 1'b0, 1'b0, 5'd0,  5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b1};
        vecs[9] = '{32'hFE001EE3, 1'b0, 1'b1, 5'd29, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b0};

        // Idle fetch after reset: request held at RESET_PC with no write.
        do_reset();
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_pc", pc, 32'h0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("idle%0d_req", c), 32'(imem_req), 32'd1);
            check($sformatf("idle%0d_addr", c), imem_addr, 32'h0);
            check($sformatf("idle%0d_rw", c), 32'(RegWrite), 32'd0);
            tick();
        end

        for (int v = 0; v < 10; v++) begin
            do_reset();
            fetch_to_exec(vecs[v].instr, v % 3, $sformatf("vec%0d", v));
            EQ = vecs[v].eq;
            check($sformatf("vec%0d_rd", v), 32'(rd), 32'(vecs[v].rd));
            check($sformatf("vec%0d_rs1", v), 32'(rs1), 32'(vecs[v].rs1));
            check($sformatf("vec%0d_rs2", v), 32'(rs2), 32'(vecs[v].rs2));
            check($sformatf("vec%0d_rw", v), 32'(RegWrite), 32'(vecs[v].regwrite));
            check($sformatf("vec%0d_exec_req", v), 32'(imem_req), 32'd0);
            if (vecs[v].legal) begin
                check($sformatf("vec%0d_alusrc", v), 32'(ALUsrc), 32'(vecs[v].alusrc));
                check($sformatf("vec%0d_aluctrl", v), 32'(ALUctrl), 32'(vecs[v].aluctrl));
                check($sformatf("vec%0d_imm", v), ImmOp, vecs[v].imm);
            end
            tick();
            check($sformatf("vec%0d_pc", v), pc, vecs[v].next_pc);
            check($sformatf("vec%0d_halt", v), 32'(halt), 32'(vecs[v].halt));
            check($sformatf("vec%0d_req", v), 32'(imem_req), 32'(!vecs[v].halt));
            check($sformatf("vec%0d_rw_after", v), 32'(RegWrite), 32'd0);
        end

        // Asynchronous reset in the middle of an addi EXEC cycle.
        do_reset();
        fetch_to_exec(32'h0FF00513, 0, "arst");
        check("arst_exec_rw", 32'(RegWrite), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rw", 32'(RegWrite), 32'd0);
        check("arst_req", 32'(imem_req), 32'd1);
        check("arst_rd", 32'(rd), 32'd0);
        check("arst_pc", pc, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("arst_pc_after", pc, 32'h0);

        // Reset pulse coinciding with imem_valid discards the word.
        do_reset();
        imem_valid = 1'b1;
        imem_rdata = 32'h0FF00513;
        #7;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_valid = 1'b0;
        check("rvalid_rd", 32'(rd), 32'd0);
        check("rvalid_req", 32'(imem_req), 32'd1);
        check("rvalid_pc", pc, 32'h0);
        check("rvalid_rw", 32'(RegWrite), 32'd0);
        tick();
        check("rvalid_rw2", 32'(RegWrite), 32'd0);
        check("rvalid_req2", 32'(imem_req), 32'd1);

        // bne at pc 0x8 with offset -8, taken then not taken.
        for (int e = 0; e < 2; e++) begin
            do_reset();
            fetch_to_exec(enc_addi(12'd1, 5'd0, 5'd5), 0, "b8");
            tick();
            fetch_to_exec(enc_addi(12'd2, 5'd0, 5'd6), 0, "b8");
            tick();
            check($sformatf("b8_%0d_addr", e), imem_addr, 32'h8);
            fetch_to_exec(enc_bne(13'h1FF8, 5'd5, 5'd6), 0, "b8");
            EQ = e[0];
            check($sformatf("b8_%0d_rw", e), 32'(RegWrite), 32'd0);
            check($sformatf("b8_%0d_imm", e), ImmOp, 32'hFFFFFFF8);
            tick();
            check($sformatf("b8_%0d_pc", e), pc, (e == 0) ? 32'h0 : 32'hC);
        end

        // Illegal instruction at pc 0x4: sticky halt, pc frozen, no more fetches.
        do_reset();
        fetch_to_exec(enc_addi(12'd7, 5'd0, 5'd1), 0, "hlt");
        tick();
        fetch_to_exec(32'h00000033, 0, "hlt");
        check("hlt_exec_rw", 32'(RegWrite), 32'd0);
        tick();
        for (int c = 0; c < 6; c++) begin
            imem_valid = 1'($urandom_range(0, 1));
            imem_rdata = enc_addi(12'd3, 5'd0, 5'd2);
            EQ         = 1'($urandom_range(0, 1));
            check($sformatf("hlt%0d_halt", c), 32'(halt), 32'd1);
            check($sformatf("hlt%0d_req", c), 32'(imem_req), 32'd0);
            check($sformatf("hlt%0d_pc", c), pc, 32'h4);
            check($sformatf("hlt%0d_rw", c), 32'(RegWrite), 32'd0);
            tick();
        end
        imem_valid = 1'b0;

        // PC wrap: reach 0xFFFFFFFC via a backward branch, then addi wraps to 0.
        do_reset();
        fetch_to_exec(enc_bne(13'h1FFC, 5'd0, 5'd0), 0, "wrap");
        EQ = 1'b0;
        tick();
        check("wrap_addr", imem_addr, 32'hFFFFFFFC);
        fetch_to_exec(enc_addi(12'h001, 5'd0, 5'd3), 1, "wrap");
        check("wrap_rw", 32'(RegWrite), 32'd1);
        tick();
        check("wrap_pc", pc, 32'h0);
        check("wrap_req", 32'(imem_req), 32'd1);

        // Random instruction stream against an instruction-level model.
        do_reset();
        m_pc = 32'h0;
        for (int i = 0; i < 200; i++) begin
            kind  = $urandom_range(0, 9);
            eq    = 1'($urandom_range(0, 1));
            f_rd  = 5'($urandom);
            f_rs1 = 5'($urandom);
            f_rs2 = 5'($urandom);
            exp_halt = 1'b0;
            simm  = 0;
            if (kind <= 4) begin
                imm12 = 12'($urandom);
                simm  = (imm12 >= 12'd2048) ? int'(imm12) - 4096 : int'(imm12);
                instr = enc_addi(imm12, f_rs1, f_rd);
                f_rs2 = instr[24:20];
                exp_pc = m_pc + 32'd4;
            end else if (kind <= 8) begin
                off = 2 * $urandom_range(0, 63) - 64;
                if ($urandom_range(0, 1) == 1) off = off & ~3;
                simm  = off;
                imm13 = 13'(off);
                instr = enc_bne(imm13, f_rs1, f_rs2);
                f_rd  = instr[11:7];
                tgt   = m_pc + 32'(off);
                if (eq) exp_pc = m_pc + 32'd4;
                else if (tgt % 4 != 0) begin
                    exp_pc   = m_pc;
                    exp_halt = 1'b1;
                end else exp_pc = tgt;
            end else begin
                instr    = ($urandom & ~32'h7F) | 32'h33;
                f_rd     = instr[11:7];
                f_rs1    = instr[19:15];
                f_rs2    = instr[24:20];
                exp_pc   = m_pc;
                exp_halt = 1'b1;
            end
            exp_q.push_back(exp_pc);

            check($sformatf("rnd%0d_addr", i), imem_addr, m_pc);
            fetch_to_exec(instr, $urandom_range(0, 2), $sformatf("rnd%0d", i));
            EQ = eq;
            check($sformatf("rnd%0d_rd", i), 32'(rd), 32'(f_rd));
            check($sformatf("rnd%0d_rs1", i), 32'(rs1), 32'(f_rs1));
            check($sformatf("rnd%0d_rs2", i), 32'(rs2), 32'(f_rs2));
            check($sformatf("rnd%0d_rw", i), 32'(RegWrite), (kind <= 4) ? 32'd1 : 32'd0);
            if (kind <= 8) begin
                check($sformatf("rnd%0d_imm", i), ImmOp, 32'(simm));
                check($sformatf("rnd%0d_alusrc", i), 32'(ALUsrc), (kind <= 4) ? 32'd1 : 32'd0);
                check($sformatf("rnd%0d_aluctrl", i), 32'(ALUctrl), (kind <= 4) ? 32'd0 : 32'd1);
            end
            tick();
            check($sformatf("rnd%0d_pc", i), pc, exp_q.pop_front());
            check($sformatf("rnd%0d_halt", i), 32'(halt), 32'(exp_halt));
            m_pc = exp_pc;
            if (exp_halt) begin
                do_reset();
                m_pc = 32'h0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 SHALL have parameter A_WIDTH, default 32, instruction address width.
REQ-002 SHALL have parameter D_WIDTH, default 32, instruction/immediate width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-007 SHALL have port imem_addr  output  A_WIDTH  fetch address (current PC).
REQ-008 SHALL have port imem_rdata  input  D_WIDTH  fetched instruction word.
REQ-009 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-010 SHALL have port EQ  input  1  datapath ALU equality flag.
REQ-011 SHALL have ports rs1, rs2, rd  output  5 each  register addresses to the datapath.
REQ-012 SHALL have port ALUsrc  output  1  1 selects ImmOp as ALU operand 2.
REQ-013 SHALL have port ALUctrl  output  1  0 = add, 1 = subtract/compare.
REQ-014 SHALL have port ImmOp  output  D_WIDTH  sign-extended immediate.
REQ-015 SHALL have port RegWrite  output  1  register file write enable.
REQ-016 SHALL have port pc  output  A_WIDTH  current PC.
REQ-017 SHALL have port halt  output  1  sticky illegal-instruction/misalignment indicator.

Function
REQ-018 SHALL implement FSM states FETCH, EXEC, HALT; reset state FETCH.
REQ-019 In FETCH: imem_req=1, imem_addr=pc; imem_req held until imem_valid=1.
REQ-020 In FETCH with imem_valid=1: latch imem_rdata into instruction register IR; next state EXEC.
REQ-021 imem_valid in EXEC or HALT SHALL be ignored; imem_req=0 in those states.
REQ-022 rs1=IR[19:15], rs2=IR[24:20], rd=IR[11:7] at all times.
REQ-023 addi (opcode 0010011, funct3 000): ALUsrc=1, ALUctrl=0, ImmOp=sign-ext IR[31:20], RegWrite=1 for exactly the single EXEC cycle.
REQ-024 bne (opcode 1100011, funct3 001): ALUsrc=0, ALUctrl=1, RegWrite=0, ImmOp=sign-ext {IR[31],IR[7],IR[30:25],IR[11:8],1'b0}.
REQ-025 RegWrite SHALL be 0 in every cycle outside EXEC and for every non-addi instruction.
REQ-026 At end of EXEC, bne with EQ=0 sampled that cycle: pc <= pc + ImmOp; otherwise pc <= pc + 4; next state FETCH.
REQ-027 PC arithmetic SHALL wrap modulo 2^A_WIDTH (0xFFFFFFFC + 4 = 0x00000000).
REQ-028 Any other opcode/funct3 in EXEC: RegWrite=0, pc unchanged, next state HALT.
REQ-029 Taken-branch target with bits[1:0] != 0: pc unchanged, next state HALT.
REQ-030 HALT SHALL be absorbing until rst; halt=1 only in HALT.
REQ-031 Fetch-to-writeback latency: 1 EXEC cycle after the imem_valid cycle; minimum 2 cycles per instruction.

Reset
REQ-032 rst=1 SHALL immediately force state FETCH, pc=RESET_PC, IR=0, halt=0, RegWrite=0, independent of clk.
REQ-033 rst asserted mid-fetch or mid-EXEC SHALL abort the instruction; no register write, no PC update; a concurrent imem_valid is discarded.
REQ-034 After rst deassertion first rising edge SHALL present imem_req=1, imem_addr=RESET_PC.

Verification
REQ-035 Reset, imem_valid held 0 for 5 cycles -> imem_req=1, imem_addr=0x0 stable, RegWrite=0 throughout.
REQ-036 Fetch 0x0FF00513 (addi a0,zero,255) at pc 0 -> next cycle rd=10, rs1=0, ALUsrc=1, ImmOp=0x000000FF, RegWrite=1 one cycle; then pc=0x4.
REQ-037 bne at pc 0x8 with offset -8, EQ=0 -> pc=0x0; same with EQ=1 -> pc=0xC; RegWrite=0 both.
REQ-038 Fetch 0x00000033 (unsupported R-type) -> halt=1 next cycle, imem_req=0 forever, pc unchanged until rst.
REQ-039 rst pulsed in cycle where imem_valid=1 -> IR not loaded, state FETCH, pc=RESET_PC, no RegWrite pulse.
REQ-040 pc=0xFFFFFFFC, addi executed -> pc=0x00000000 after EXEC.
